// File: rtl/reg_file.sv
// Operand register file feeding the ALU: two combinational read ports with write bypass,
// one write port, and the architectural zero flag captured from the ALU.
module reg_file #(
    parameter  int unsigned DATA_W   = 8,
    parameter  int unsigned NUM_REGS = 8,
    localparam int unsigned AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rd_addr,
    input  logic [AW-1:0]     rs_addr,
    output logic [DATA_W-1:0] r0_rd,
    output logic [DATA_W-1:0] rs,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              z_en,
    input  logic              z_in,
    output logic              z_flag
);

    localparam int unsigned ADDR_EXT_W = 32;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_z_flag;

    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_rs_in_range;
    logic              w_wr_fire;
    logic              w_rd_bypass;
    logic              w_rs_bypass;
    logic [DATA_W-1:0] w_rd_stored;
    logic [DATA_W-1:0] w_rs_stored;

    // Addresses at or beyond NUM_REGS only exist for non-power-of-two sizes.
    always_comb begin
        w_wr_in_range = (ADDR_EXT_W'(wr_addr) < ADDR_EXT_W'(NUM_REGS));
        w_rd_in_range = (ADDR_EXT_W'(rd_addr) < ADDR_EXT_W'(NUM_REGS));
        w_rs_in_range = (ADDR_EXT_W'(rs_addr) < ADDR_EXT_W'(NUM_REGS));
    end

    // Reset is level-sensitive here too so a write presented during reset never leaks out.
    always_comb begin
        w_wr_fire   = wr_en && rst_n && w_wr_in_range;
        w_rd_bypass = w_wr_fire && (wr_addr == rd_addr);
        w_rs_bypass = w_wr_fire && (wr_addr == rs_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_flag <= 1'b0;
        end else if (z_en) begin
            r_z_flag <= z_in;
        end
    end

    always_comb begin
        w_rd_stored = '0;
        w_rs_stored = '0;
        if (w_rd_in_range) begin
            w_rd_stored = r_regs[rd_addr];
        end
        if (w_rs_in_range) begin
            w_rs_stored = r_regs[rs_addr];
        end
    end

    // Same-cycle write data wins so a dependent instruction needs no stall.
    always_comb begin
        r0_rd = w_rd_bypass ? wr_data : w_rd_stored;
        rs    = w_rs_bypass ? wr_data : w_rs_stored;
    end

    assign z_flag = r_z_flag;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed vector table, reset/flag corner sequences, and random
// traffic checked against an array-based reference model.
module tb_reg_file;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned AW       = 3;

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     rs_addr;
    logic [DATA_W-1:0] r0_rd;
    logic [DATA_W-1:0] rs;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              z_en;
    logic              z_in;
    logic              z_flag;

    int checks = 0;
    int errors = 0;

    reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_addr(rd_addr),
        .rs_addr(rs_addr),
        .r0_rd  (r0_rd),
        .rs     (rs),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .z_en   (z_en),
        .z_in   (z_in),
        .z_flag (z_flag)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       z_en;
        logic       z_in;
        logic [2:0] ra;
        logic [2:0] sa;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ez;
    } vec_t;

    function automatic vec_t mk(logic rn, logic we, logic [2:0] wa, logic [7:0] wd,
                                logic ze, logic zi, logic [2:0] ra, logic [2:0] sa,
                                logic [7:0] e0, logic [7:0] e1, logic ez);
        vec_t v;
        v.rst_n = rn; v.wr_en = we; v.wa = wa; v.wd = wd; v.z_en = ze; v.z_in = zi;
        v.ra = ra; v.sa = sa; v.e0 = e0; v.e1 = e1; v.ez = ez;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic ze, input logic zi,
                         input logic [2:0] ra, input logic [2:0] sa);
        rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd;
        z_en = ze; z_in = zi; rd_addr = ra; rs_addr = sa;
    endtask

    vec_t tbl[14];
    logic [7:0] model_regs [NUM_REGS];
    logic       model_z;

    initial begin
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);

        // Cycle-by-cycle vectors: expected outputs are sampled before the row's edge.
        tbl[0]  = mk(0, 1, 3'd5, 8'hFF, 1, 1, 3'd5, 3'd5, 8'h00, 8'h00, 0);
        tbl[1]  = mk(1, 1, 3'd5, 8'h3C, 0, 0, 3'd5, 3'd0, 8'h3C, 8'h00, 0);
        tbl[2]  = mk(1, 0, 3'd0, 8'h00, 0, 0, 3'd5, 3'd5, 8'h3C, 8'h3C, 0);
        tbl[3]  = mk(1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd7, 8'h00, 8'h00, 0);
        tbl[4]  = mk(1, 1, 3'd3, 8'h55, 0, 0, 3'd3, 3'd4, 8'h55, 8'h00, 0);
        tbl[5]  = mk(1, 1, 3'd2, 8'h7F, 0, 0, 3'd2, 3'd3, 8'h7F, 8'h55, 0);
        tbl[6]  = mk(1, 1, 3'd4, 8'h11, 1, 1, 3'd4, 3'd4, 8'h11, 8'h11, 0);
        tbl[7]  = mk(1, 0, 3'd0, 8'h00, 0, 0, 3'd2, 3'd4, 8'h7F, 8'h11, 1);
        tbl[8]  = mk(1, 0, 3'd0, 8'h00, 1, 0, 3'd5, 3'd3, 8'h3C, 8'h55, 1);
        tbl[9]  = mk(1, 1, 3'd1, 8'h01, 0, 0, 3'd1, 3'd0, 8'h01, 8'h00, 0);
        tbl[10] = mk(1, 1, 3'd1, 8'h02, 0, 0, 3'd1, 3'd1, 8'h02, 8'h02, 0);
        tbl[11] = mk(1, 0, 3'd0, 8'h00, 0, 0, 3'd1, 3'd2, 8'h02, 8'h7F, 0);
        tbl[12] = mk(1, 1, 3'd0, 8'hA5, 1, 1, 3'd0, 3'd0, 8'hA5, 8'hA5, 0);
        tbl[13] = mk(1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd1, 8'hA5, 8'h02, 1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].rst_n, tbl[i].wr_en, tbl[i].wa, tbl[i].wd,
                  tbl[i].z_en, tbl[i].z_in, tbl[i].ra, tbl[i].sa);
            #1;
            chk($sformatf("tbl%0d_r0_rd", i), r0_rd, tbl[i].e0);
            chk($sformatf("tbl%0d_rs", i), rs, tbl[i].e1);
            chk($sformatf("tbl%0d_z_flag", i), 8'(z_flag), 8'(tbl[i].ez));
        end

        // Fill every register with AA and set the flag, then reset mid-cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 3'(i), 8'hAA, 1'b1, 1'b1, 3'd0, 3'd0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 3'd7);
        #1;
        chk("fill_r0_rd", r0_rd, 8'hAA);
        chk("fill_z_flag", 8'(z_flag), 8'h01);
        #2;
        drive(1'b0, 1'b1, 3'd6, 8'h99, 1'b1, 1'b1, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            rs_addr = 3'(7 - i);
            #1;
            chk($sformatf("rst_async_r0_rd_a%0d", i), r0_rd, 8'h00);
            chk($sformatf("rst_async_rs_a%0d", i), rs, 8'h00);
        end
        chk("rst_async_z_flag", 8'(z_flag), 8'h00);
        @(posedge clk);
        #1;
        rd_addr = 3'd6;
        #1;
        chk("rst_hold_write_ignored", r0_rd, 8'h00);
        chk("rst_hold_z_ignored", 8'(z_flag), 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd6, 8'h99, 1'b0, 1'b0, 3'd5, 3'd6);
        #1;
        chk("post_rst_bypass", rs, 8'h99);
        chk("post_rst_r5_cleared", r0_rd, 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd6, 3'd0);
        #1;
        chk("post_rst_first_write", r0_rd, 8'h99);

        // Random traffic against the reference model.
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_regs[6] = 8'h99;
        model_z = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic       rn;
            logic [7:0] exp0;
            logic [7:0] exp1;
            @(negedge clk);
            rn = ($urandom_range(0, 31) != 0);
            drive(rn, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 3'($urandom));
            if (!rn) begin
                for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
                model_z = 1'b0;
            end
            exp0 = model_regs[rd_addr];
            exp1 = model_regs[rs_addr];
            if (rn && wr_en && wr_addr == rd_addr) exp0 = wr_data;
            if (rn && wr_en && wr_addr == rs_addr) exp1 = wr_data;
            #1;
            chk($sformatf("rand%0d_r0_rd", cyc), r0_rd, exp0);
            chk($sformatf("rand%0d_rs", cyc), rs, exp1);
            chk($sformatf("rand%0d_z_flag", cyc), 8'(z_flag), 8'(model_z));
            if (rn) begin
                if (wr_en) model_regs[wr_addr] = wr_data;
                if (z_en) model_z = z_in;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
